// File: rtl/score_scan_ctrl_pkg.sv
// Purpose: shared constants for the Pong score/scan display path (package pong_display_pkg).
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
// Contents: digit-select slot codes, blank digit value, score width, winner encoding.
package pong_display_pkg;

  localparam int SCORE_W = 4;

  // Digit-select codes as seen by the 7-segment decoder.
  localparam logic [1:0] SLOT_RIGHT = 2'd0;
  localparam logic [1:0] SLOT_BLANK = 2'd1;
  localparam logic [1:0] SLOT_LEFT  = 2'd2;

  localparam logic [SCORE_W-1:0] NUM_BLANK = 4'hF;

  localparam logic WINNER_LEFT  = 1'b0;
  localparam logic WINNER_RIGHT = 1'b1;

endpackage

// File: rtl/score_scan_ctrl_if.sv
// Purpose: bundles the score/scan controller's control inputs and display/status outputs.
// Latency: n/a (wiring only).
// Backpressure: none; the display outputs are valid every cycle.
// Ports: clear, point_left, point_right (to controller); en, num, score_left, score_right,
//        game_over, winner (from controller). master = stimulus side, slave = controller side.
interface score_scan_ctrl_if;
  import pong_display_pkg::*;

  logic               clear;
  logic               point_left;
  logic               point_right;
  logic [1:0]         en;
  logic [SCORE_W-1:0] num;
  logic [SCORE_W-1:0] score_left;
  logic [SCORE_W-1:0] score_right;
  logic               game_over;
  logic               winner;

  modport master (
    output clear, point_left, point_right,
    input  en, num, score_left, score_right, game_over, winner
  );

  modport slave (
    input  clear, point_left, point_right,
    output en, num, score_left, score_right, game_over, winner
  );

endinterface

// File: rtl/score_scan_ctrl_tick_gen.sv
// Purpose: free-running prescaler; one-cycle tick on the terminal count of 0..DIV-1.
// Latency: first tick DIV cycles after reset/clr release, then every DIV cycles.
// Backpressure: none; clr restarts the count synchronously.
// Ports: clk, reset (sync, active-high), clr (sync restart), tick (registered-count decode).
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/score_scan_ctrl.sv
// Purpose: Pong score keeper with game-over detection and 4-slot digit scan for the 7-seg decoder.
// Latency: scores/status update on the edge after a pulse; num follows en combinationally.
// Backpressure: none; point pulses are dropped while game_over is set.
// Ports: clk, reset (sync, active-high), bus (score_scan_ctrl_if.slave).
// Optional: define SCORE_FLASH_EN to blink the winning score after game over (FLASH_DIV phases).
module score_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int WIN_SCORE   = 9,
  parameter int FLASH_DIV   = 25000000
) (
  input  logic              clk,
  input  logic              reset,
  score_scan_ctrl_if.slave  bus
);
  import pong_display_pkg::*;

  if (REFRESH_DIV < 2) begin : g_bad_refresh
    $error("REFRESH_DIV must be at least 2");
  end
  if (WIN_SCORE < 1 || WIN_SCORE > 9) begin : g_bad_win
    $error("WIN_SCORE must be in 1..9");
  end
  if (FLASH_DIV < 2) begin : g_bad_flash
    $error("FLASH_DIV must be at least 2");
  end

  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  logic               refresh_tick;
  logic [1:0]         scan_q;
  logic [SCORE_W-1:0] sl_q, sr_q, sl_inc, sr_inc;
  logic               go_q, win_q;

  tick_gen #(.DIV(REFRESH_DIV)) u_refresh (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .tick  (refresh_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_q <= SLOT_RIGHT;
    end else if (refresh_tick) begin
      scan_q <= scan_q + 2'd1;
    end
  end

  assign sl_inc = sl_q + SCORE_W'(bus.point_left);
  assign sr_inc = sr_q + SCORE_W'(bus.point_right);

  // Scores stop at WIN because game_over freezes them on the edge they get there.
  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      sl_q  <= '0;
      sr_q  <= '0;
      go_q  <= 1'b0;
      win_q <= WINNER_LEFT;
    end else if (!go_q) begin
      sl_q <= sl_inc;
      sr_q <= sr_inc;
      if (sl_inc == WIN || sr_inc == WIN) begin
        go_q  <= 1'b1;
        // Left is tested first so a simultaneous finish goes to left.
        win_q <= (sl_inc == WIN) ? WINNER_LEFT : WINNER_RIGHT;
      end
    end
  end

  always_comb begin
    bus.num = NUM_BLANK;
    case (scan_q)
      SLOT_RIGHT: bus.num = sr_q;
      SLOT_BLANK: bus.num = NUM_BLANK;
      SLOT_LEFT:  bus.num = sl_q;
      2'd3:       bus.num = NUM_BLANK;
    endcase
  end

`ifdef SCORE_FLASH_EN
  logic       flash_tick;
  logic       phase_q;
  logic [1:0] win_slot;

  // Prescaler held in restart while no game is over so every blink phase is full length.
  tick_gen #(.DIV(FLASH_DIV)) u_flash (
    .clk   (clk),
    .reset (reset),
    .clr   (!go_q),
    .tick  (flash_tick)
  );

  always_ff @(posedge clk) begin
    if (reset || !go_q) begin
      phase_q <= 1'b0;
    end else if (flash_tick) begin
      phase_q <= ~phase_q;
    end
  end

  assign win_slot = (win_q == WINNER_RIGHT) ? SLOT_RIGHT : SLOT_LEFT;

  // Gated with go_q too: phase_q can still be set for the one cycle after a clear.
  assign bus.en = (go_q && phase_q && scan_q == win_slot) ? SLOT_BLANK : scan_q;
`else
  assign bus.en = scan_q;
`endif

  assign bus.score_left  = sl_q;
  assign bus.score_right = sr_q;
  assign bus.game_over   = go_q;
  assign bus.winner      = win_q;

endmodule

// File: tb/tb_score_scan_ctrl.sv
// Purpose: randomized + directed bench for score_scan_ctrl with a cycle-count based reference model.
// Latency: expected state pushed at each active edge, compared on the following falling edge.
// Backpressure: n/a; outputs are checked every cycle.
module tb_score_scan_ctrl;

  localparam int RD = 4;
  localparam int WS = 3;
  localparam int FD = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  score_scan_ctrl_if bus();

  score_scan_ctrl #(
    .REFRESH_DIV (RD),
    .WIN_SCORE   (WS),
    .FLASH_DIV   (FD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int en;
    int num;
    int sl;
    int sr;
    int go;
    int win;
  } exp_t;

  exp_t q[$];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Reference state: cycles since reset, scores, game status, cycles since game over.
  int m_k   = 0;
  int m_sl  = 0;
  int m_sr  = 0;
  int m_go  = 0;
  int m_win = 0;
  int m_g   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
  endtask

  function automatic exp_t model_view();
    exp_t e;
    int   slot;
    slot  = (m_k / RD) % 4;
    e.en  = slot;
    e.num = (slot == 0) ? m_sr : (slot == 2) ? m_sl : 15;
`ifdef SCORE_FLASH_EN
    if (m_go == 1 && ((m_g / FD) % 2) == 1 && slot == ((m_win == 1) ? 0 : 2)) e.en = 1;
`endif
    e.sl  = m_sl;
    e.sr  = m_sr;
    e.go  = m_go;
    e.win = m_win;
    return e;
  endfunction

  task automatic model_edge(input bit r, input bit c, input bit pl, input bit pr);
    if (r) begin
      m_k = 0; m_sl = 0; m_sr = 0; m_go = 0; m_win = 0; m_g = 0;
    end else begin
      m_k++;
      if (m_go == 1) m_g++;
      if (c) begin
        m_sl = 0; m_sr = 0; m_go = 0; m_win = 0;
      end else if (m_go == 0) begin
        m_sl += int'(pl);
        m_sr += int'(pr);
        if (m_sl == WS || m_sr == WS) begin
          m_go  = 1;
          m_win = (m_sl == WS) ? 0 : 1;
          m_g   = 0;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit c, input bit pl, input bit pr);
    @(negedge clk);
    reset           = r;
    bus.clear       = c;
    bus.point_left  = pl;
    bus.point_right = pr;
    @(posedge clk);
    model_edge(r, c, pl, pr);
    q.push_back(model_view());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: pops one expectation per cycle and compares every output.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("en",          int'(bus.en),          e.en);
        chk("num",         int'(bus.num),         e.num);
        chk("score_left",  int'(bus.score_left),  e.sl);
        chk("score_right", int'(bus.score_right), e.sr);
        chk("game_over",   int'(bus.game_over),   e.go);
        chk("winner",      int'(bus.winner),      e.win);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset           = 1'b1;
    bus.clear       = 1'b0;
    bus.point_left  = 1'b0;
    bus.point_right = 1'b0;

    // Reset, then plain scanning.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    idle(32);

    // Right wins 3-0 with gaps between pulses; long idle exposes any blink.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      idle($urandom_range(1, 6));
    end
    idle(40);

    // From 2/2, both score together: left takes the tie.
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    idle(3);
    step(0, 0, 1, 1);
    idle(40);

    // Pulses while game over are ignored; clear beats a simultaneous point.
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    idle(2);
    step(0, 1, 0, 1);
    idle(6);

    // Mid-game reset landing on slot 2 with prescaler at 2.
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    while ((m_k % (4 * RD)) != (2 * RD + 2)) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    idle(2 * RD + 3);

    // Randomized play with occasional clears and resets.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0));
    end
    idle(4);

    repeat (2) @(posedge clk);
    chk("drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
